spi_ram_arbiter: RTL

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_arbiter.sv
//==============================================================================
// spi_ram_arbiter : shares one single-port RAM between an SPI command stream
//                   and a host port. Optional macro HOST_PRIORITY_EN.
// Revision 1.0
//==============================================================================
`default_nettype none

module spi_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              spi_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_RET  = 2'd3
  } state_t;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                spi_pend_q, spi_pend_d;
  logic                spi_we_q, spi_we_d;
  logic [ADDR_W-1:0]   spi_addr_q, spi_addr_d;
  logic [DATA_W-1:0]   spi_data_q, spi_data_d;
  logic                spi_ovf_q, spi_ovf_d;
  logic                last_spi_q, last_spi_d;
  logic                sel_spi_q, sel_spi_d;
  logic                acc_we_q, acc_we_d;
  logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0]   acc_data_q, acc_data_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   h_rdata_q, h_rdata_d;

  logic [1:0]          rx_op;
  logic [DATA_W-1:0]   rx_payload;
  logic [ADDR_W-1:0]   rx_addr;
  logic                spi_take;
  logic                win_spi;

  // Addresses come from the low bits of the payload, so ADDR_W <= DATA_W.
  assign rx_op      = rx_data[DATA_W+1:DATA_W];
  assign rx_payload = rx_data[DATA_W-1:0];
  assign rx_addr    = rx_data[ADDR_W-1:0];
  assign spi_take   = (state_q == ST_ACCESS) && sel_spi_q;

  always_comb begin
    win_spi = spi_pend_q;
    if (h_req && spi_pend_q) begin
`ifdef HOST_PRIORITY_EN
      win_spi = 1'b0;
`else
      win_spi = !last_spi_q;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    spi_pend_d = spi_pend_q;
    spi_we_d   = spi_we_q;
    spi_addr_d = spi_addr_q;
    spi_data_d = spi_data_q;
    spi_ovf_d  = spi_ovf_q;
    last_spi_d = last_spi_q;
    sel_spi_d  = sel_spi_q;
    acc_we_d   = acc_we_q;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    h_rdata_d  = h_rdata_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    h_gnt      = 1'b0;
    h_rvalid   = 1'b0;

    if (spi_take) begin
      spi_pend_d = 1'b0;
    end

    // A queued command may refill the slot in the same cycle it is consumed.
    if (rx_valid) begin
      case (rx_op)
        OP_WADDR: wr_addr_d = rx_addr;
        OP_RADDR: begin
          rd_addr_d  = rx_addr;
          tx_valid_d = 1'b0;
        end
        OP_WRITE, OP_READ: begin
          if (rx_op == OP_READ) begin
            tx_valid_d = 1'b0;
          end
          if (!spi_pend_q || spi_take) begin
            spi_pend_d = 1'b1;
            spi_we_d   = (rx_op == OP_WRITE);
            spi_addr_d = (rx_op == OP_WRITE) ? wr_addr_q : rd_addr_q;
            spi_data_d = rx_payload;
          end else begin
            spi_ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (h_req || spi_pend_q) begin
          sel_spi_d  = win_spi;
          last_spi_d = win_spi;
          acc_we_d   = win_spi ? spi_we_q   : h_we;
          acc_addr_d = win_spi ? spi_addr_q : h_addr;
          acc_data_d = win_spi ? spi_data_q : h_wdata;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = acc_we_q;
        h_gnt   = !sel_spi_q;
        state_d = acc_we_q ? ST_IDLE : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Loading the return registers here makes them visible during RD_RET.
        if (sel_spi_q) begin
          tx_data_d  = mem_dout;
          tx_valid_d = 1'b1;
        end else begin
          h_rdata_d = mem_dout;
        end
        state_d = ST_RD_RET;
      end
      ST_RD_RET: begin
        h_rvalid = !sel_spi_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      spi_pend_q <= 1'b0;
      spi_we_q   <= 1'b0;
      spi_addr_q <= '0;
      spi_data_q <= '0;
      spi_ovf_q  <= 1'b0;
      last_spi_q <= 1'b0;
      sel_spi_q  <= 1'b0;
      acc_we_q   <= 1'b0;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      h_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      spi_pend_q <= spi_pend_d;
      spi_we_q   <= spi_we_d;
      spi_addr_q <= spi_addr_d;
      spi_data_q <= spi_data_d;
      spi_ovf_q  <= spi_ovf_d;
      last_spi_q <= last_spi_d;
      sel_spi_q  <= sel_spi_d;
      acc_we_q   <= acc_we_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      h_rdata_q  <= h_rdata_d;
    end
  end

  assign mem_addr = acc_addr_q;
  assign mem_din  = acc_data_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign h_rdata  = h_rdata_q;
  assign spi_ovf  = spi_ovf_q;

endmodule

`default_nettype wire
